// File: rtl/vliw_scb_pkg.sv
// Shared constants and types for the VLIW issue scoreboard.
// Holds the default register-address width, lane count and per-lane latency table.
package vliw_scb_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int DEF_NUM_LANES = 10;
  localparam int DEF_MAX_LAT   = 16;
  localparam int LAT_W         = 5;

  // Lane 0 sits in the least significant field: lanes 0..9 = 4,4,13,3,3,13,1,2,2,2.
  localparam logic [DEF_NUM_LANES*LAT_W-1:0] LANE_LAT_DEF = {
    5'd2, 5'd2, 5'd2, 5'd1, 5'd13, 5'd3, 5'd3, 5'd13, 5'd4, 5'd4
  };

  typedef logic [$clog2(DEF_NUM_LANES)-1:0] lane_idx_t;
  typedef logic [REG_ADDR_W-1:0]            reg_addr_t;

endpackage

// File: rtl/scb_lane_pipe.sv
// One issue lane's in-flight tracker: a DEPTH-stage {valid,dst} shift pipeline.
// The last stage is the writeback strobe; busy_o decodes every live stage's destination.
module scb_lane_pipe
  import vliw_scb_pkg::*;
#(
  parameter int DEPTH  = 1,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 load_i,
  input  logic [ADDR_W-1:0]    dst_i,
  output logic                 wb_valid_o,
  output logic [ADDR_W-1:0]    wb_dst_o,
  output logic [2**ADDR_W-1:0] busy_o
);

  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][ADDR_W-1:0] dst_q, dst_d;

  // Empty stages carry dst 0 so wb_dst reads 0 whenever no strobe is present.
  always_comb begin
    vld_d = '0;
    dst_d = '0;
    if (!flush_i) begin
      vld_d[0] = load_i;
      dst_d[0] = load_i ? dst_i : '0;
      for (int s = 1; s < DEPTH; s++) begin
        vld_d[s] = vld_q[s-1];
        dst_d[s] = dst_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dst_q <= '0;
    end else begin
      vld_q <= vld_d;
      dst_q <= dst_d;
    end
  end

  assign wb_valid_o = vld_q[DEPTH-1];
  assign wb_dst_o   = dst_q[DEPTH-1];

  always_comb begin
    busy_o = '0;
    for (int s = 0; s < DEPTH; s++) begin
      if (vld_q[s]) busy_o[dst_q[s]] = 1'b1;
    end
  end

endmodule

// File: rtl/vliw_issue_scoreboard.sv
// VLIW issue scoreboard: tracks pending register writes per lane and stalls hazardous packets.
// Define VLIW_SCB_WB_BYPASS_EN to let a register being written back this cycle satisfy sources.
module vliw_issue_scoreboard
  import vliw_scb_pkg::*;
#(
  parameter int                           NUM_LANES  = DEF_NUM_LANES,
  parameter int                           REG_ADDR_W = vliw_scb_pkg::REG_ADDR_W,
  parameter int                           MAX_LAT    = DEF_MAX_LAT,
  parameter logic [NUM_LANES*LAT_W-1:0]   LANE_LAT   = LANE_LAT_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 issue_valid,
  output logic                                 issue_ready,
  input  logic [NUM_LANES-1:0]                 lane_valid,
  input  logic [NUM_LANES-1:0][REG_ADDR_W-1:0] lane_dst,
  input  logic [NUM_LANES-1:0][REG_ADDR_W-1:0] lane_src_a,
  input  logic [NUM_LANES-1:0][REG_ADDR_W-1:0] lane_src_b,
  input  logic [NUM_LANES-1:0][1:0]            lane_src_en,
  input  logic                                 flush,
  output logic [NUM_LANES-1:0]                 wb_valid,
  output logic [NUM_LANES-1:0][REG_ADDR_W-1:0] wb_dst,
  output logic [2**REG_ADDR_W-1:0]             busy_vec,
  output logic [15:0]                          stall_cnt
);

  localparam int NREGS = 2**REG_ADDR_W;

  // Handshake: a packet transfers on a rising edge where issue_valid && issue_ready && !flush;
  // issue_ready depends only on current busy state and the offered packet, never on issue_valid.
  logic                             accept;
  logic                             hazard;
  logic [NUM_LANES-1:0][NREGS-1:0]  lane_busy;
  logic [NREGS-1:0]                 src_block;
  logic [15:0]                      stall_cnt_q, stall_cnt_d;

  assign accept = issue_valid && issue_ready && !flush;

  // Writes to register 0 are discarded, so r0 never goes busy and never strobes.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam int LAT = int'(LANE_LAT[g*LAT_W +: LAT_W]);
    if (LAT == 0 || LAT > MAX_LAT) begin : g_bad_lat
      $error("vliw_issue_scoreboard: lane %0d latency %0d outside 1..%0d", g, LAT, MAX_LAT);
    end
    scb_lane_pipe #(
      .DEPTH  ((LAT < 1) ? 1 : LAT),
      .ADDR_W (REG_ADDR_W)
    ) u_pipe (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush),
      .load_i     (accept && lane_valid[g] && (lane_dst[g] != '0)),
      .dst_i      (lane_dst[g]),
      .wb_valid_o (wb_valid[g]),
      .wb_dst_o   (wb_dst[g]),
      .busy_o     (lane_busy[g])
    );
  end

  always_comb begin
    busy_vec = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      busy_vec = busy_vec | lane_busy[l];
    end
  end

`ifdef VLIW_SCB_WB_BYPASS_EN
  logic [NREGS-1:0] wb_map;

  // A value on the writeback path this cycle is forwarded to readers.
  always_comb begin
    wb_map = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (wb_valid[l]) wb_map[wb_dst[l]] = 1'b1;
    end
  end

  assign src_block = busy_vec & ~wb_map;
`else
  assign src_block = busy_vec;
`endif

  // Sources naming another lane's destination in the same packet read the old value: no check.
  always_comb begin
    hazard = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (lane_valid[l]) begin
        if (lane_src_en[l][0] && src_block[lane_src_a[l]]) hazard = 1'b1;
        if (lane_src_en[l][1] && src_block[lane_src_b[l]]) hazard = 1'b1;
        if (busy_vec[lane_dst[l]])                         hazard = 1'b1;
        for (int m = l + 1; m < NUM_LANES; m++) begin
          if (lane_valid[m] && (lane_dst[m] == lane_dst[l]) && (lane_dst[l] != '0)) hazard = 1'b1;
        end
      end
    end
    issue_ready = !hazard;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (issue_valid && !issue_ready && !flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_vliw_issue_scoreboard.sv
// Directed bench for vliw_issue_scoreboard: writeback expectations go to a queue that a
// negedge monitor matches against every wb_valid strobe; combinational/state checks are inline.
module tb_vliw_issue_scoreboard;

  localparam int NL = 10;
  localparam int AW = 5;
  localparam int EW = 32 + 4 + AW;

`ifdef VLIW_SCB_WB_BYPASS_EN
  localparam int EXP_SRC_STALL = 11;
`else
  localparam int EXP_SRC_STALL = 12;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [NL-1:0]         lane_valid;
  logic [NL-1:0][AW-1:0] lane_dst, lane_src_a, lane_src_b;
  logic [NL-1:0][1:0]    lane_src_en;
  logic                  flush;
  logic [NL-1:0]         wb_valid;
  logic [NL-1:0][AW-1:0] wb_dst;
  logic [31:0]           busy_vec;
  logic [15:0]           stall_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_stall = 0;
  int lat_tbl [NL] = '{4, 4, 13, 3, 3, 13, 1, 2, 2, 2};
  logic [EW-1:0] exp_q[$];

  vliw_issue_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .lane_valid  (lane_valid),
    .lane_dst    (lane_dst),
    .lane_src_a  (lane_src_a),
    .lane_src_b  (lane_src_b),
    .lane_src_en (lane_src_en),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_dst      (wb_dst),
    .busy_vec    (busy_vec),
    .stall_cnt   (stall_cnt)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_lanes();
    issue_valid = 1'b0;
    flush       = 1'b0;
    lane_valid  = '0;
    lane_dst    = '0;
    lane_src_a  = '0;
    lane_src_b  = '0;
    lane_src_en = '0;
  endtask

  task automatic set_lane(input int l, input int dst, input int sa, input int sb, input logic [1:0] en);
    lane_valid[l]  = 1'b1;
    lane_dst[l]    = AW'(dst);
    lane_src_a[l]  = AW'(sa);
    lane_src_b[l]  = AW'(sb);
    lane_src_en[l] = en;
  endtask

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  // Called in the cycle whose closing edge accepts the packet.
  task automatic expect_wb(input int l, input int dst);
    exp_q.push_back({32'(cyc + lat_tbl[l]), 4'(l), AW'(dst)});
  endtask

  task automatic flush_sb();
    for (int k = exp_q.size() - 1; k >= 0; k--) begin
      if (int'(exp_q[k][EW-1:4+AW]) > cyc) exp_q.delete(k);
    end
  endtask

  // Monitor: every strobe must match a queued expectation; overdue entries are missed strobes.
  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (wb_valid[l]) begin
        automatic bit found = 1'b0;
        automatic logic [EW-1:0] key = {32'(cyc), 4'(l), wb_dst[l]};
        for (int k = 0; k < exp_q.size(); k++) begin
          if (!found && exp_q[k] == key) begin
            exp_q.delete(k);
            found = 1'b1;
          end
        end
        checks++;
        if (!found) begin
          errors++;
          $display("FAIL wb_strobe: lane %0d dst %0d at cycle %0d, expected no such writeback", l, wb_dst[l], cyc);
        end
      end
    end
    for (int k = exp_q.size() - 1; k >= 0; k--) begin
      if (int'(exp_q[k][EW-1:4+AW]) < cyc) begin
        checks++;
        errors++;
        $display("FAIL wb_missing: lane %0d dst %0d due cycle %0d, got no strobe",
                 exp_q[k][AW+3:AW], exp_q[k][AW-1:0], exp_q[k][EW-1:4+AW]);
        exp_q.delete(k);
      end
    end
  end

  initial begin
    int n;
    clear_lanes();
    repeat (3) @(negedge clk);
    #1;
    check("rst_wb_valid", 64'(wb_valid), 64'h0);
    check("rst_wb_dst", 64'(wb_dst), 64'h0);
    check("rst_busy", 64'(busy_vec), 64'h0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    rst_n = 1'b1;
    next();

    // Full packet, intra-packet sources reading other lanes' destinations: no conflict.
    for (int l = 0; l < NL; l++) set_lane(l, l + 1, ((l + 1) % NL) + 1, ((l + 2) % NL) + 1, 2'b11);
    #1;
    check("ready_after_reset", 64'(issue_ready), 64'h1);
    clear_lanes();

    // Single lane-0 write to r5: strobe 4 cycles on, busy for 4 cycles.
    set_lane(0, 5, 0, 0, 2'b00);
    issue_valid = 1'b1;
    #1;
    check("t1_ready", 64'(issue_ready), 64'h1);
    expect_wb(0, 5);
    next();
    clear_lanes();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy_vec == 32'h0000_0020) n++;
      next();
    end
    check("t1_busy_cycles", 64'(n), 64'd4);

    // RAW: lane2 writes r7 (13 cycles); one idle cycle, then lane0 reads r7.
    set_lane(2, 7, 0, 0, 2'b00);
    issue_valid = 1'b1;
    #1;
    check("t2_ready_first", 64'(issue_ready), 64'h1);
    expect_wb(2, 7);
    next();
    clear_lanes();
    next();
    set_lane(0, 1, 7, 0, 2'b01);
    issue_valid = 1'b1;
    #1;
    for (int i = 0; i < EXP_SRC_STALL; i++) begin
      check("t2_src_stall", 64'(issue_ready), 64'h0);
      next();
    end
    check("t2_src_release", 64'(issue_ready), 64'h1);
    expect_wb(0, 1);
    next();
    clear_lanes();
    exp_stall += EXP_SRC_STALL;
    check("t2_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    repeat (6) next();

    // WAW: destination stalls through its writeback cycle even with forwarding.
    set_lane(3, 8, 0, 0, 2'b00);
    issue_valid = 1'b1;
    #1;
    check("t2b_ready_first", 64'(issue_ready), 64'h1);
    expect_wb(3, 8);
    next();
    clear_lanes();
    set_lane(4, 8, 0, 0, 2'b00);
    issue_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t2b_dst_stall", 64'(issue_ready), 64'h0);
      next();
    end
    check("t2b_dst_release", 64'(issue_ready), 64'h1);
    expect_wb(4, 8);
    next();
    clear_lanes();
    exp_stall += 3;
    check("t2b_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    repeat (5) next();

    // Duplicate destination in one packet; then lane1 retargets r0 and reads r9 (old value).
    set_lane(0, 9, 0, 0, 2'b00);
    set_lane(1, 9, 0, 0, 2'b00);
    issue_valid = 1'b1;
    #1;
    check("t3_dup_dst", 64'(issue_ready), 64'h0);
    next();
    exp_stall += 1;
    set_lane(1, 0, 9, 0, 2'b11);
    #1;
    check("t3_r0_accept", 64'(issue_ready), 64'h1);
    expect_wb(0, 9);
    next();
    clear_lanes();
    check("t3_busy", 64'(busy_vec), 64'h0000_0200);
    check("t3_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    repeat (6) next();

    // Flush: lane5 r3 in flight, flush while a reader of r3 is stalled.
    set_lane(5, 3, 0, 0, 2'b00);
    issue_valid = 1'b1;
    #1;
    expect_wb(5, 3);
    next();
    clear_lanes();
    repeat (3) next();
    check("t4_busy_before", 64'(busy_vec), 64'h0000_0008);
    flush = 1'b1;
    issue_valid = 1'b1;
    set_lane(0, 12, 3, 0, 2'b01);
    #1;
    check("t4_ready_at_flush", 64'(issue_ready), 64'h0);
    flush_sb();
    next();
    clear_lanes();
    check("t4_busy_after", 64'(busy_vec), 64'h0);
    check("t4_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    flush = 1'b1;
    issue_valid = 1'b1;
    set_lane(0, 12, 0, 0, 2'b00);
    #1;
    check("t4_ready_clean", 64'(issue_ready), 64'h1);
    next();
    clear_lanes();
    check("t4_accept_suppressed", 64'(busy_vec), 64'h0);
    set_lane(0, 4, 3, 3, 2'b11);
    issue_valid = 1'b1;
    #1;
    check("t4_src3_accept", 64'(issue_ready), 64'h1);
    expect_wb(0, 4);
    next();
    clear_lanes();
    repeat (16) next();

    // Async reset mid-flight with three pending lanes.
    set_lane(0, 22, 0, 0, 2'b00);
    set_lane(2, 20, 0, 0, 2'b00);
    set_lane(5, 21, 0, 0, 2'b00);
    issue_valid = 1'b1;
    #1;
    check("t5_ready", 64'(issue_ready), 64'h1);
    expect_wb(0, 22);
    expect_wb(2, 20);
    expect_wb(5, 21);
    next();
    clear_lanes();
    next();
    check("t5_busy_pending", 64'(busy_vec), 64'h0070_0000);
    rst_n = 1'b0;
    exp_q.delete();
    exp_stall = 0;
    #1;
    check("t5_rst_wb_valid", 64'(wb_valid), 64'h0);
    check("t5_rst_wb_dst", 64'(wb_dst), 64'h0);
    check("t5_rst_busy", 64'(busy_vec), 64'h0);
    check("t5_rst_stall_cnt", 64'(stall_cnt), 64'h0);
    next();
    next();
    rst_n = 1'b1;
    repeat (20) next();
    check("t5_busy_quiet", 64'(busy_vec), 64'h0);

    // Stall counter saturation via a held duplicate-destination packet.
    set_lane(0, 9, 0, 0, 2'b00);
    set_lane(1, 9, 0, 0, 2'b00);
    issue_valid = 1'b1;
    #1;
    repeat (65534) next();
    check("t6_stall_fffe", 64'(stall_cnt), 64'hFFFE);
    repeat (70000 - 65534) next();
    check("t6_stall_sat", 64'(stall_cnt), 64'hFFFF);
    check("t6_ready_low", 64'(issue_ready), 64'h0);
    clear_lanes();
    repeat (5) next();
    check("t6_stall_hold", 64'(stall_cnt), 64'hFFFF);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vliw_issue_scoreboard.md
VLIW_ISSUE_SCOREBOARD -- requirements
Module: vliw_issue_scoreboard

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 10, number of issue slots per packet.
REQ-002 The block SHALL have parameter REG_ADDR_W, default 5, register address width (2**REG_ADDR_W registers).
REQ-003 The block SHALL have parameter MAX_LAT, default 16, upper bound on any lane latency.
REQ-004 The block SHALL have parameter LANE_LAT, packed NUM_LANES x 5 bits, default {4,4,13,3,3,13,1,2,2,2} for lanes 0..9: cycles from accept to writeback.
REQ-005 The block SHALL have port clk, input, 1, the single clock; reset is asynchronous and active-low.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port issue_valid, input, 1, packet offered.
REQ-008 The block SHALL have port issue_ready, output, 1, packet accepted this cycle if issue_valid.
REQ-009 The block SHALL have port lane_valid, input, NUM_LANES, lane carries a register-writing op.
REQ-010 The block SHALL have ports lane_dst, lane_src_a and lane_src_b, input, NUM_LANES x REG_ADDR_W, destination and source registers.
REQ-011 The block SHALL have port lane_src_en, input, NUM_LANES x 2, per-lane source-used flags {b,a}.
REQ-012 The block SHALL have port flush, input, 1, synchronous kill of all in-flight ops.
REQ-013 The block SHALL have ports wb_valid (output, NUM_LANES) and wb_dst (output, NUM_LANES x REG_ADDR_W), the per-lane writeback strobe and address.
REQ-014 The block SHALL have ports busy_vec (output, 2**REG_ADDR_W, pending-write map) and stall_cnt (output, 16, saturating stall counter).

Function
REQ-015 Accept SHALL occur on a rising clk edge when issue_valid && issue_ready && !flush.
REQ-016 issue_ready SHALL be combinational: low if any valid lane's enabled source, or its destination, is set in busy_vec.
REQ-017 issue_ready SHALL also be low if two valid lanes in one packet name the same non-zero lane_dst.
REQ-018 Sources that name the destination of another lane in the same packet SHALL NOT stall (VLIW read-old semantics).
REQ-019 Register 0 SHALL never be marked busy and SHALL never cause a stall.
REQ-020 For lane l accepted at edge T, wb_valid[l] SHALL be high for exactly one cycle, following edge T+LANE_LAT[l]-1, with wb_dst[l] equal to the accepted lane_dst[l].
REQ-021 busy_vec[r] SHALL be set from the cycle after accept through the cycle wb_valid for r is high, inclusive.
REQ-022 Two lanes SHALL never assert wb_valid with the same wb_dst in one cycle; this is guaranteed by REQ-016.
REQ-023 flush SHALL clear all in-flight entries at the next edge, suppress any accept that cycle, and leave stall_cnt unchanged.
REQ-024 stall_cnt SHALL increment on each cycle where issue_valid && !issue_ready && !flush, and SHALL saturate at 16'hFFFF.
REQ-025 A LANE_LAT entry of 0 or greater than MAX_LAT SHALL be an elaboration error.

Reset
REQ-026 On rst_n low, all pipeline entries SHALL clear asynchronously: wb_valid=0, wb_dst=0, busy_vec=0, stall_cnt=0.
REQ-027 Reset asserted mid-operation SHALL discard in-flight ops with no writeback strobe.
REQ-028 After reset, issue_ready SHALL be 1 for any packet free of intra-packet conflict.

Configuration
REQ-029 With VLIW_SCB_WB_BYPASS_EN defined, a register whose wb_valid is high in the current cycle SHALL NOT stall a source read (forwarded), but SHALL still stall as a destination.
REQ-030 Without VLIW_SCB_WB_BYPASS_EN, such a register SHALL stall both source and destination use until the following cycle.

Structure
REQ-031 Package vliw_scb_pkg SHALL hold REG_ADDR_W, the default LANE_LAT table, the lane-index typedef and the reg-address typedef.
REQ-032 Sub-module scb_lane_pipe SHALL implement one lane's depth-LANE_LAT {valid,dst} shift pipeline with flush, instantiated NUM_LANES times.

Verification
REQ-033 Reset, then a packet with lane0 dst=5 -> wb_valid[0]=1 with wb_dst=5 exactly 4 cycles later; busy_vec[5] high for 4 cycles.
REQ-034 Lane2 dst=7, then the next packet has lane0 src_a=7 -> issue_ready=0 for 12 cycles (11 with bypass), and stall_cnt advances by the same count.
REQ-035 Packet with lane0 dst=9 and lane1 dst=9 -> issue_ready=0 and no accept; change lane1 dst to 0 -> accepted.
REQ-036 Lane5 dst=3 in flight, flush at cycle 5 -> busy_vec=0 next cycle, no wb_valid[5] ever; a packet with src=3 is then accepted.
REQ-037 rst_n pulsed low mid-flight with 3 lanes pending -> all outputs 0 immediately, no strobes afterward.
REQ-038 Force 70000 stall cycles -> stall_cnt holds at 16'hFFFF.
